// File: rtl/fft16_sequencer_if.sv
// Bus bundle for fft16_sequencer: sample input stream, butterfly operand/result
// port and spectrum output stream.
interface fft16_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;

  logic              bf_valid;
  logic [DATA_W-1:0] bf_ra;
  logic [DATA_W-1:0] bf_ca;
  logic [DATA_W-1:0] bf_rb;
  logic [DATA_W-1:0] bf_cb;
  logic [3:0]        bf_twiddle_num;
  logic [DATA_W-1:0] bf_res_ra;
  logic [DATA_W-1:0] bf_res_ca;
  logic [DATA_W-1:0] bf_res_rb;
  logic [DATA_W-1:0] bf_res_cb;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_real;
  logic [DATA_W-1:0] m_imag;

  modport master (
    input  s_valid, s_real, s_imag,
    output s_ready,
    output bf_valid, bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num,
    input  bf_res_ra, bf_res_ca, bf_res_rb, bf_res_cb,
    output m_valid, m_real, m_imag,
    input  m_ready
  );

  modport slave (
    output s_valid, s_real, s_imag,
    input  s_ready,
    input  bf_valid, bf_ra, bf_ca, bf_rb, bf_cb, bf_twiddle_num,
    output bf_res_ra, bf_res_ca, bf_res_rb, bf_res_cb,
    input  m_valid, m_real, m_imag,
    output m_ready
  );
endinterface

// File: rtl/fft16_sequencer.sv
// 16-point radix-2 DIT FFT sequencer: owns the in-place sample buffer and feeds an
// external pipelined butterfly unit, stage by stage, with writeback of its results.
module fft16_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  fft16_sequencer_if.master bus,
  output logic              busy
);
  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, UNLOAD} state_t;

  state_t state, state_nxt;

  logic [3:0]        cnt;
  logic [2:0]        k;
  logic [1:0]        stage;
  logic [DATA_W-1:0] mem_re [16];
  logic [DATA_W-1:0] mem_im [16];

  logic [BFLY_LAT-1:0] wb_v;
  logic [3:0]          wb_a [BFLY_LAT];
  logic [3:0]          wb_b [BFLY_LAT];

  logic              s_ready_q, bf_valid_q, m_valid_q;
  logic [3:0]        bf_a_q, bf_b_q, bf_tw_q;
  logic [DATA_W-1:0] bf_ra_q, bf_ca_q, bf_rb_q, bf_cb_q;
  logic [DATA_W-1:0] m_re_q, m_im_q;

  logic       s_fire_c, m_fire_c, pend_c, drain_done_c;
  logic [3:0] span_c, grp_c, addr_a_c, addr_b_c, tw_c, ld_addr_c;
  logic [2:0] pos_c;

  assign s_fire_c = bus.s_valid && s_ready_q;
  assign m_fire_c = m_valid_q && bus.m_ready;

  // Butterfly addressing for the current (stage, k); load address is bitrev4(cnt)
  always_comb begin
    span_c    = 4'(1) << stage;
    pos_c     = k & (span_c[2:0] - 3'd1);
    grp_c     = {1'b0, k} >> stage;
    addr_a_c  = (grp_c << (3'(stage) + 3'd1)) | {1'b0, pos_c};
    addr_b_c  = addr_a_c | span_c;
    tw_c      = {1'b0, pos_c} << (2'd3 - stage);
    ld_addr_c = {cnt[0], cnt[1], cnt[2], cnt[3]};
  end

  // Drain ends once only the oldest writeback (landing this edge) is left in flight
  always_comb begin
    pend_c = bf_valid_q;
    for (int i = 0; i < int'(BFLY_LAT) - 1; i++) pend_c = pend_c | wb_v[i];
    drain_done_c = !pend_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (s_fire_c && cnt == 4'd15) state_nxt = ISSUE;
      ISSUE:   if (k == 3'd7) state_nxt = DRAIN;
      DRAIN:   if (drain_done_c) state_nxt = (stage == 2'd3) ? UNLOAD : ISSUE;
      UNLOAD:  if (m_fire_c && cnt == 4'd15) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Counters, operand registers, writeback pipe and output stream registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      k          <= '0;
      stage      <= '0;
      s_ready_q  <= 1'b0;
      busy       <= 1'b0;
      bf_valid_q <= 1'b0;
      bf_a_q     <= '0;
      bf_b_q     <= '0;
      bf_tw_q    <= '0;
      bf_ra_q    <= '0;
      bf_ca_q    <= '0;
      bf_rb_q    <= '0;
      bf_cb_q    <= '0;
      m_valid_q  <= 1'b0;
      m_re_q     <= '0;
      m_im_q     <= '0;
      wb_v       <= '0;
      for (int i = 0; i < int'(BFLY_LAT); i++) begin
        wb_a[i] <= '0;
        wb_b[i] <= '0;
      end
    end else begin
      s_ready_q  <= (state_nxt == LOAD);
      busy       <= (state_nxt != LOAD);
      bf_valid_q <= (state == ISSUE);

      if ((state == LOAD && s_fire_c) || (state == UNLOAD && m_fire_c)) cnt <= cnt + 4'd1;
      if (state == ISSUE) k <= k + 3'd1;
      if (state == DRAIN && drain_done_c) stage <= stage + 2'd1;

      if (state == ISSUE) begin
        bf_a_q  <= addr_a_c;
        bf_b_q  <= addr_b_c;
        bf_tw_q <= tw_c;
        bf_ra_q <= mem_re[addr_a_c];
        bf_ca_q <= mem_im[addr_a_c];
        bf_rb_q <= mem_re[addr_b_c];
        bf_cb_q <= mem_im[addr_b_c];
      end

      wb_v[0] <= bf_valid_q;
      wb_a[0] <= bf_a_q;
      wb_b[0] <= bf_b_q;
      for (int i = 1; i < int'(BFLY_LAT); i++) begin
        wb_v[i] <= wb_v[i-1];
        wb_a[i] <= wb_a[i-1];
        wb_b[i] <= wb_b[i-1];
      end

      // Final stage-3 writeback touches buf[7]/buf[15], never buf[0]
      if (state == DRAIN && state_nxt == UNLOAD) begin
        m_valid_q <= 1'b1;
        m_re_q    <= mem_re[0];
        m_im_q    <= mem_im[0];
      end else if (m_fire_c) begin
        if (cnt == 4'd15) begin
          m_valid_q <= 1'b0;
        end else begin
          m_re_q <= mem_re[4'(cnt + 4'd1)];
          m_im_q <= mem_im[4'(cnt + 4'd1)];
        end
      end
    end
  end

  // Sample buffer: loaded in bit-reversed order, updated in place by writebacks
  always_ff @(posedge clk) begin
    if (state == LOAD && s_fire_c) begin
      mem_re[ld_addr_c] <= bus.s_real;
      mem_im[ld_addr_c] <= bus.s_imag;
    end
    if (wb_v[BFLY_LAT-1]) begin
      mem_re[wb_a[BFLY_LAT-1]] <= bus.bf_res_ra;
      mem_im[wb_a[BFLY_LAT-1]] <= bus.bf_res_ca;
      mem_re[wb_b[BFLY_LAT-1]] <= bus.bf_res_rb;
      mem_im[wb_b[BFLY_LAT-1]] <= bus.bf_res_cb;
    end
  end

  assign bus.s_ready        = s_ready_q;
  assign bus.bf_valid       = bf_valid_q;
  assign bus.bf_ra          = bf_ra_q;
  assign bus.bf_ca          = bf_ca_q;
  assign bus.bf_rb          = bf_rb_q;
  assign bus.bf_cb          = bf_cb_q;
  assign bus.bf_twiddle_num = bf_tw_q;
  assign bus.m_valid        = m_valid_q;
  assign bus.m_real         = m_re_q;
  assign bus.m_imag         = m_im_q;
endmodule

// File: tb/tb_fft16_sequencer.sv
// Scoreboard bench for fft16_sequencer with a behavioural pipelined butterfly
// (loopback or floating-point reference rounded to integers).
module tb_fft16_sequencer;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 3;
  localparam int TIMEOUT = 2000;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  fft16_sequencer_if #(.DATA_W(DW)) bus();

  fft16_sequencer #(.DATA_W(DW), .BFLY_LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_re[$];
  int exp_im[$];
  bit loopback = 1'b1;
  bit stall    = 1'b0;
  bit addr_chk = 1'b0;
  int tol      = 0;
  int issue_cnt = 0;

  task automatic check(input string tag, input int got, input int exp, input int tl);
    n_checks++;
    if (got - exp > tl || exp - got > tl) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tl, $time);
    end
  endtask

  function automatic int brev4(input int v);
    return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Behavioural butterfly unit: result of operands seen at edge t appears for edge t+LAT
  logic [DW-1:0] p_ra [LAT];
  logic [DW-1:0] p_ca [LAT];
  logic [DW-1:0] p_rb [LAT];
  logic [DW-1:0] p_cb [LAT];

  always @(posedge clk) begin
    int ar, ai, br, bi;
    int ra, ca, rb, cb;
    real wr, wi, tr, ti;
    ar = int'($signed(bus.bf_ra));
    ai = int'($signed(bus.bf_ca));
    br = int'($signed(bus.bf_rb));
    bi = int'($signed(bus.bf_cb));
    if (loopback) begin
      ra = ar; ca = ai; rb = br; cb = bi;
    end else begin
      wr = $cos(2.0 * PI * real'(int'(bus.bf_twiddle_num)) / 16.0);
      wi = -$sin(2.0 * PI * real'(int'(bus.bf_twiddle_num)) / 16.0);
      tr = real'(br) * wr - real'(bi) * wi;
      ti = real'(br) * wi + real'(bi) * wr;
      ra = rnd(real'(ar) + tr);
      ca = rnd(real'(ai) + ti);
      rb = rnd(real'(ar) - tr);
      cb = rnd(real'(ai) - ti);
    end
    p_ra[0] <= DW'(ra);
    p_ca[0] <= DW'(ca);
    p_rb[0] <= DW'(rb);
    p_cb[0] <= DW'(cb);
    for (int i = 1; i < int'(LAT); i++) begin
      p_ra[i] <= p_ra[i-1];
      p_ca[i] <= p_ca[i-1];
      p_rb[i] <= p_rb[i-1];
      p_cb[i] <= p_cb[i-1];
    end
  end

  assign bus.bf_res_ra = p_ra[LAT-1];
  assign bus.bf_res_ca = p_ca[LAT-1];
  assign bus.bf_res_rb = p_rb[LAT-1];
  assign bus.bf_res_cb = p_cb[LAT-1];

  // Output monitor: issue-order/address checks, stall stability, scoreboard pops
  initial begin : out_mon
    logic [DW-1:0] hold_re, hold_im;
    bit held;
    bit sready_next;
    int out_cnt;
    int s, kk, span, pos, a, b, tw;
    held = 0; sready_next = 0; out_cnt = 0;
    hold_re = '0; hold_im = '0;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0; sready_next = 0; out_cnt = 0; issue_cnt = 0;
      end else begin
        if (sready_next) begin
          check("s_ready_after_beat15", int'(bus.s_ready), 1, 0);
          sready_next = 0;
        end
        if (bus.bf_valid) begin
          if (addr_chk) begin
            s = issue_cnt / 8; kk = issue_cnt % 8;
            span = 1 << s; pos = kk % span;
            a = (kk >> s) * 2 * span + pos; b = a + span;
            tw = pos << (3 - s);
            check($sformatf("bf_a s%0d k%0d", s, kk), brev4(int'(bus.bf_ra[3:0])), a, 0);
            check($sformatf("bf_b s%0d k%0d", s, kk), brev4(int'(bus.bf_rb[3:0])), b, 0);
            check($sformatf("bf_tw s%0d k%0d", s, kk), int'(bus.bf_twiddle_num), tw, 0);
          end
          issue_cnt = (issue_cnt + 1) % 32;
        end
        if (held) begin
          check("m_valid_held", int'(bus.m_valid), 1, 0);
          check("m_real_stable", int'(bus.m_real), int'(hold_re), 0);
          check("m_imag_stable", int'(bus.m_imag), int'(hold_im), 0);
        end
        if (bus.m_valid) check("s_ready_in_unload", int'(bus.s_ready), 0, 0);
        bus.m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.m_valid && bus.m_ready) begin
          if (exp_re.size() == 0) begin
            check("unexpected_beat", 1, 0, 0);
          end else begin
            check($sformatf("m_real[%0d]", out_cnt), int'($signed(bus.m_real)), exp_re.pop_front(), tol);
            check($sformatf("m_imag[%0d]", out_cnt), int'($signed(bus.m_imag)), exp_im.pop_front(), tol);
          end
          out_cnt = (out_cnt + 1) % 16;
          sready_next = (out_cnt == 0);
          held = 0;
        end else begin
          held    = bus.m_valid;
          hold_re = bus.m_real;
          hold_im = bus.m_imag;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_re.delete();
    exp_im.delete();
    repeat (2) @(negedge clk);
    check("rst s_ready", int'(bus.s_ready), 0, 0);
    check("rst busy", int'(busy), 0, 0);
    check("rst bf_valid", int'(bus.bf_valid), 0, 0);
    check("rst m_valid", int'(bus.m_valid), 0, 0);
    check("rst m_real", int'(bus.m_real), 0, 0);
    check("rst bf_ra", int'(bus.bf_ra), 0, 0);
    check("rst bf_tw", int'(bus.bf_twiddle_num), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst s_ready", int'(bus.s_ready), 1, 0);
    check("post_rst bf_valid", int'(bus.bf_valid), 0, 0);
    check("post_rst busy", int'(busy), 0, 0);
  endtask

  // Push the expected spectrum, then stream the frame in; returns just after the beat-15 edge
  task automatic load_frame(input int xr[16], input int xi[16], input bit gaps);
    real sr, si, th;
    int t;
    for (int j = 0; j < 16; j++) begin
      if (loopback) begin
        exp_re.push_back(xr[brev4(j)]);
        exp_im.push_back(xi[brev4(j)]);
      end else begin
        sr = 0.0; si = 0.0;
        for (int n = 0; n < 16; n++) begin
          th = 2.0 * PI * real'(n * j) / 16.0;
          sr = sr + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
          si = si + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
        end
        exp_re.push_back(rnd(sr));
        exp_im.push_back(rnd(si));
      end
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_real  = DW'(xr[n]);
      bus.s_imag  = DW'(xi[n]);
      t = 0;
      while (!bus.s_ready && t < TIMEOUT) begin
        @(negedge clk);
        t++;
      end
      if (t >= TIMEOUT) begin
        check("s_ready_timeout", 0, 1, 0);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_re.size() != 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) check("drain_timeout", exp_re.size(), 0, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_frame(output int xr[16], output int xi[16]);
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($urandom_range(0, 1023)) - 512;
      xi[n] = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  initial begin : main
    int xr[16];
    int xi[16];
    int cyc;
    int t;
    bus.s_valid = 1'b0;
    bus.s_real  = '0;
    bus.s_imag  = '0;
    do_reset();

    // Loopback frame x[n]=(n,0): addresses/twiddles, bit-reversed output, latency
    loopback = 1'b1; addr_chk = 1'b1; tol = 0;
    for (int n = 0; n < 16; n++) begin xr[n] = n; xi[n] = 0; end
    load_frame(xr, xi, 1'b0);
    cyc = 0;
    while (!bus.m_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("beat15_to_m_valid", cyc, 4 * (8 + int'(LAT) + 1), 0);
    wait_drain();
    addr_chk = 1'b0;

    // Impulse through the reference butterfly
    loopback = 1'b0; tol = 2;
    for (int n = 0; n < 16; n++) begin xr[n] = 0; xi[n] = 0; end
    xr[0] = 16384;
    load_frame(xr, xi, 1'b0);
    wait_drain();

    // Random frame with input gaps, ignored s_valid while busy, random m_ready stalls
    tol = 3; stall = 1'b1;
    rand_frame(xr, xi);
    load_frame(xr, xi, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_real  = 16'h7fff;
    bus.s_imag  = 16'h8000;
    t = 0;
    while (!bus.m_valid && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    bus.s_valid = 1'b0;
    if (t >= TIMEOUT) check("m_valid_timeout", 0, 1, 0);
    wait_drain();
    stall = 1'b0;

    // Reset during stage-2 drain, then a fresh frame
    rand_frame(xr, xi);
    load_frame(xr, xi, 1'b0);
    t = 0;
    while (!(issue_cnt == 24 && !bus.bf_valid) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) check("stage2_drain_timeout", 0, 1, 0);
    do_reset();
    rand_frame(xr, xi);
    load_frame(xr, xi, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft16_sequencer.md
FFT16_SEQUENCER -- requirements
Module: fft16_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the component width (data_size+1, two's complement, Q1.15).
REQ-002 The block SHALL have parameter BFLY_LAT, default 3, giving the butterfly_unit latency in cycles (range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports s_valid (input, 1), s_ready (output, 1), s_real (input, DATA_W) and s_imag (input, DATA_W): the time-domain sample input, natural order.
REQ-006 The block SHALL have ports bf_valid (output, 1), bf_ra, bf_ca, bf_rb and bf_cb (output, DATA_W each) and bf_twiddle_num (output, 4): registered operands to butterfly_unit.
REQ-007 The block SHALL have ports bf_res_ra, bf_res_ca, bf_res_rb and bf_res_cb (input, DATA_W each): butterfly_unit results.
REQ-008 The block SHALL have ports m_valid (output, 1), m_ready (input, 1), m_real (output, DATA_W) and m_imag (output, DATA_W): the frequency-domain output, natural order.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than LOAD.

Function
REQ-010 The block SHALL hold a 16-entry complex register buffer, updated in place across all four radix-2 DIT stages.
REQ-011 The block SHALL implement the states LOAD, ISSUE, DRAIN and UNLOAD, entering LOAD after reset.
REQ-012 In LOAD, s_ready SHALL be 1; each s_valid&&s_ready beat n (0..15) SHALL be written to address bitrev4(n).
REQ-013 The block SHALL go LOAD->ISSUE on the edge accepting beat 15, with stage=0 and k=0.
REQ-014 In ISSUE, one butterfly k (0..7) SHALL be issued per cycle, in order, with bf_valid=1 and operands registered (valid in the cycle after the state/k decision).
REQ-015 Addresses for stage s (0..3) SHALL be: span=2^s, pos=k mod span, a=(k>>s)*2*span+pos, b=a+span; bf_ra/bf_ca=buf[a], bf_rb/bf_cb=buf[b], bf_twiddle_num=pos<<(3-s).
REQ-016 After k=7 the block SHALL go ISSUE->DRAIN; bf_valid SHALL be 0 at all times outside the 8 issue cycles.
REQ-017 For operands presented with bf_valid=1 in cycle t, the block SHALL sample bf_res_* at the edge ending cycle t+BFLY_LAT, writing ra/ca to buf[a] and rb/cb to buf[b], using a BFLY_LAT-deep valid/address shift register.
REQ-018 DRAIN SHALL last until the writeback shift register is empty; it then SHALL go to ISSUE with stage+1, or to UNLOAD if stage=3.
REQ-019 The next stage's first read SHALL see all writebacks of the previous stage; no read SHALL bypass a pending write.
REQ-020 In UNLOAD, m_valid SHALL be 1 with m_real/m_imag=buf[j] for j=0..15, advancing j only on m_valid&&m_ready.
REQ-021 m_real/m_imag SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 After beat j=15 is accepted, the block SHALL go to LOAD, with s_ready=1 in the next cycle.
REQ-023 s_valid outside LOAD SHALL be ignored (s_ready=0); m_ready outside UNLOAD SHALL be ignored.
REQ-024 No arithmetic SHALL be performed in this block; data SHALL pass bit-exact between ports and buffer.
REQ-025 One frame SHALL take 16 load beats + 4*(8+BFLY_LAT+1) cycles in ISSUE/DRAIN + 16 unload beats (no stalls).

Reset
REQ-026 While rst=1, and on rst assertion at any time (including mid-frame), the block SHALL force state=LOAD, all counters=0, the writeback pipe empty, and bf_valid=m_valid=busy=0.
REQ-027 The same reset SHALL force bf_ra/ca/rb/cb=0, bf_twiddle_num=0, m_real=m_imag=0 and s_ready=0.
REQ-028 On reset, the partial frame SHALL be discarded.
REQ-029 Buffer contents SHALL need not be cleared on reset.
REQ-030 s_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-031 Loopback bench: bf_res_* = operands delayed by BFLY_LAT; load x[n]=(n,0) -> outputs m_real[j]=bitrev4(j) for j=0..15 (0,8,4,12,...).
REQ-032 Address/twiddle check: stage0 k=0 -> a=0,b=1,tw=0; stage2 k=5 -> a=9,b=13,tw=2; stage3 k=7 -> a=7,b=15,tw=7.
REQ-033 Reference butterfly model, impulse x[0]=(0x4000,0), rest 0 -> all 16 outputs equal a golden FFT within ±2 LSB; BFLY_LAT=3 and 1 both pass.
REQ-034 m_ready toggled randomly during UNLOAD -> no beat dropped or duplicated, data stable while stalled, s_ready=1 only after beat 15.
REQ-035 rst pulsed in stage 2 DRAIN, then a new frame loaded -> the first output equals the new frame's result; bf_valid=0 during and right after reset.
REQ-036 Cycle count with continuous handshakes and BFLY_LAT=3 -> exactly 48 cycles from accepting beat 15 to first m_valid.
